lsu: RTL

Load/store unit in the execute → writeback path. It consumes the integer ALU result, which is the effective address for loads and stores and the final result for everything else. It runs a req/gnt/rvalid handshake on the data bus and presents one registered writeback transaction per accepted instruction. The FSM is multi-cycle, so only one instruction is in flight at a time.

---
 rtl/lsu.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: req/gnt/rvalid data-bus master with one registered writeback per instruction.
// Optional misaligned-access fault: define LSU_MISALIGN_CHECK_EN.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic        ex_load_i,
  input  logic        ex_store_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  ex_rd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        wb_err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lo_q, lo_d;
  logic [4:0]       rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        ex_ready_d, mem_req_d, mem_we_d, wb_valid_d, wb_we_d, wb_err_d;
  logic [3:0]  mem_be_d;
  logic [31:0] mem_addr_d, mem_wdata_d, wb_data_d;
  logic [4:0]  wb_rd_d;

  // Request-side decode of the incoming instruction
  logic        ex_is_mem, ex_is_store, ex_misalign;
  logic [3:0]  ex_be;
  logic [31:0] ex_wrep;

  always_comb begin
    ex_is_mem   = ex_load_i | ex_store_i;
    ex_is_store = ex_store_i & ~ex_load_i;
    unique case (ex_funct3_i[1:0])
      2'b00: begin
        ex_be    = 4'b0001 << ex_addr_i[1:0];
        ex_wrep  = {4{ex_wdata_i[7:0]}};
        ex_misalign = 1'b0;
      end
      2'b01: begin
        ex_be    = 4'b0011 << {ex_addr_i[1], 1'b0};
        ex_wrep  = {2{ex_wdata_i[15:0]}};
        ex_misalign = ex_addr_i[0];
      end
      default: begin
        ex_be    = 4'b1111;
        ex_wrep  = ex_wdata_i;
        ex_misalign = (ex_addr_i[1:0] != 2'b00);
      end
    endcase
  end

  // Load lane extraction and sign/zero extension
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  always_comb begin
    rd_byte = 8'(mem_rdata_i >> {lo_q, 3'b000});
    rd_half = lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    unique case (f3_q[1:0])
      2'b00:   load_data = f3_q[2] ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_data = f3_q[2] ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_data = mem_rdata_i;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    ex_ready_d  = ex_ready_o;
    mem_req_d   = mem_req_o;
    mem_we_d    = mem_we_o;
    mem_be_d    = mem_be_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    wb_valid_d  = wb_valid_o;
    wb_we_d     = wb_we_o;
    wb_rd_d     = wb_rd_o;
    wb_data_d   = wb_data_o;
    wb_err_d    = wb_err_o;

    unique case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          f3_d       = ex_funct3_i;
          lo_d       = ex_addr_i[1:0];
          rd_d       = ex_rd_i;
          wb_rd_d    = ex_rd_i;
          ex_ready_d = 1'b0;
          if (!ex_is_mem) begin
            state_d    = DONE;
            wb_valid_d = 1'b1;
            wb_we_d    = (ex_rd_i != 5'd0);
            wb_data_d  = ex_addr_i;
            wb_err_d   = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
          end else if (ex_misalign) begin
            state_d    = DONE;
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_data_d  = 32'd0;
            wb_err_d   = 1'b1;
`endif
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = ex_is_store;
            mem_addr_d  = {ex_addr_i[31:2], 2'b00};
            mem_be_d    = ex_is_store ? ex_be : 4'b0000;
            mem_wdata_d = ex_is_store ? ex_wrep : 32'd0;
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (mem_we_o) begin
            state_d    = DONE;
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_data_d  = 32'd0;
            wb_err_d   = 1'b0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          wb_we_d    = (rd_q != 5'd0);
          wb_data_d  = load_data;
          wb_err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d    = DONE;
          cnt_d      = cnt_q + CNT_W'(1);
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          wb_data_d  = 32'd0;
          wb_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (wb_ready_i) begin
          state_d    = IDLE;
          wb_valid_d = 1'b0;
          ex_ready_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      f3_q        <= 3'd0;
      lo_q        <= 2'd0;
      rd_q        <= 5'd0;
      cnt_q       <= '0;
      ex_ready_o  <= 1'b1;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'd0;
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
      wb_valid_o  <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_rd_o     <= 5'd0;
      wb_data_o   <= 32'd0;
      wb_err_o    <= 1'b0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      ex_ready_o  <= ex_ready_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_be_o    <= mem_be_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      wb_valid_o  <= wb_valid_d;
      wb_we_o     <= wb_we_d;
      wb_rd_o     <= wb_rd_d;
      wb_data_o   <= wb_data_d;
      wb_err_o    <= wb_err_d;
    end
  end

endmodule
